// File: rtl/ascii_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ascii_pkg
//  Description : Shared byte constants, mode encodings and FSM state type
//                for the ASCII line streamer and its nibble map.
//  Revision    : 1.0  initial release
// ============================================================================
package ascii_pkg;

    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_SEMI = 8'h3B;
    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_A    = 8'h41;

    localparam logic MODE_LEGACY = 1'b0;
    localparam logic MODE_HEX    = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DIGIT = 3'd1,
        ST_SEP   = 3'd2,
        ST_CR    = 3'd3,
        ST_LF    = 3'd4
    } streamer_state_t;

endpackage
`default_nettype wire

// File: rtl/ascii_nibble_map.sv
`default_nettype none
// ============================================================================
//  Module      : ascii_nibble_map
//  Description : Combinational 4-bit code -> ASCII byte table. Digits map to
//                '0'..'9' in both modes; A-F map to 'A'..'F' in hex mode or
//                to the legacy control/punctuation codes otherwise.
//  Revision    : 1.0  initial release
// ============================================================================
module ascii_nibble_map
    import ascii_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_mode,
    output logic [7:0] o_ascii
);

    // Table lookup: decimal digits shared, letters depend on mode
    always_comb begin
        o_ascii = ASCII_ZERO + {4'h0, i_nibble};
        if (i_nibble > 4'd9) begin
            if (i_mode == MODE_HEX) begin
                o_ascii = ASCII_A + {4'h0, i_nibble - 4'd10};
            end else begin
                case (i_nibble)
                    4'hC:    o_ascii = ASCII_CR;
                    4'hD:    o_ascii = ASCII_LF;
                    4'hE:    o_ascii = ASCII_SEMI;
                    4'hF:    o_ascii = 8'h46;
                    default: o_ascii = ASCII_CR;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ascii_line_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : ascii_line_streamer
//  Description : Serialises words of DIGITS nibbles into ASCII bytes (MSB
//                nibble first) with a separator between words and CR LF after
//                WORDS_PER_LINE words or on flush.
//                Optional macro ZERO_SUPPRESS_EN skips leading zero nibbles
//                (the last nibble is always emitted).
//  Revision    : 1.0  initial release
// ============================================================================
module ascii_line_streamer
    import ascii_pkg::*;
#(
    parameter int         DIGITS         = 4,
    parameter int         WORDS_PER_LINE = 8,
    parameter logic [7:0] SEP_CHAR       = 8'h3B
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mode,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   in_data,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [7:0]            out_byte,
    output logic                  busy
);

    localparam int         DW        = 4 * DIGITS;
    localparam logic [2:0] LAST_IDX  = 3'(DIGITS - 1);
    localparam logic [7:0] LINE_LAST = 8'(WORDS_PER_LINE - 1);

    streamer_state_t state_q, state_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      wcnt_q, wcnt_d;
    logic            flush_pend_q, flush_pend_d;
    logic [DW-1:0]   data_q, data_d;
    logic            mode_q, mode_d;
    logic [7:0]      out_byte_q, out_byte_d;
    logic            out_valid_q, out_valid_d;

    logic [2:0]      start_idx;
    logic [3:0]      cur_nibble;
    logic [7:0]      cur_ascii;
    logic            accept_in;
    logic            accept_out;

    assign in_ready   = (state_q == ST_IDLE) && rst_n;
    assign accept_in  = in_valid && in_ready;
    assign accept_out = out_valid_q && out_ready;
    assign busy       = (state_q != ST_IDLE);
    assign out_valid  = out_valid_q;
    assign out_byte   = out_byte_q;

    // First nibble index to emit for an incoming word
    always_comb begin
`ifdef ZERO_SUPPRESS_EN
        start_idx = 3'd0;
        for (int i = 1; i < DIGITS; i++) begin
            if (in_data[4*i +: 4] != 4'h0) begin
                start_idx = 3'(i);
            end
        end
`else
        start_idx = LAST_IDX;
`endif
    end

    // Next-state logic: word latch, nibble index, word count, pending flush
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        wcnt_d       = wcnt_q;
        flush_pend_d = flush_pend_q;
        data_d       = data_q;
        mode_d       = mode_q;

        if (flush && (state_q != ST_IDLE)) begin
            flush_pend_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept_in) begin
                    data_d  = in_data;
                    mode_d  = mode;
                    idx_d   = start_idx;
                    state_d = ST_DIGIT;
                    if (flush) begin
                        flush_pend_d = 1'b1;
                    end
                end else if (flush && (wcnt_q != 8'd0)) begin
                    state_d = ST_CR;
                end
            end
            ST_DIGIT: begin
                if (accept_out) begin
                    if (idx_q != 3'd0) begin
                        idx_d = idx_q - 3'd1;
                    end else if ((wcnt_q == LINE_LAST) || flush_pend_q || flush) begin
                        state_d = ST_CR;
                    end else begin
                        wcnt_d  = wcnt_q + 8'd1;
                        state_d = ST_SEP;
                    end
                end
            end
            ST_SEP: begin
                if (accept_out) begin
                    state_d = ST_IDLE;
                end
            end
            ST_CR: begin
                if (accept_out) begin
                    state_d = ST_LF;
                end
            end
            ST_LF: begin
                if (accept_out) begin
                    wcnt_d       = 8'd0;
                    flush_pend_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Nibble selected for the byte that will be presented next cycle
    assign cur_nibble = 4'(data_d >> {idx_d, 2'b00});

    ascii_nibble_map u_map (
        .i_nibble (cur_nibble),
        .i_mode   (mode_d),
        .o_ascii  (cur_ascii)
    );

    // Output byte is loaded for the state being entered (or re-held on stall)
    always_comb begin
        out_valid_d = 1'b1;
        out_byte_d  = 8'h00;
        case (state_d)
            ST_IDLE:  out_valid_d = 1'b0;
            ST_DIGIT: out_byte_d  = cur_ascii;
            ST_SEP:   out_byte_d  = SEP_CHAR;
            ST_CR:    out_byte_d  = ASCII_CR;
            ST_LF:    out_byte_d  = ASCII_LF;
            default:  out_valid_d = 1'b0;
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= 3'd0;
            wcnt_q       <= 8'd0;
            flush_pend_q <= 1'b0;
            data_q       <= '0;
            mode_q       <= MODE_LEGACY;
            out_byte_q   <= 8'h00;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            wcnt_q       <= wcnt_d;
            flush_pend_q <= flush_pend_d;
            data_q       <= data_d;
            mode_q       <= mode_d;
            out_byte_q   <= out_byte_d;
            out_valid_q  <= out_valid_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ascii_line_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ascii_line_streamer
//  Description : Directed self-checking bench for ascii_line_streamer
//                (DIGITS=4, WORDS_PER_LINE=2). Expected byte streams are
//                hand-computed; ZERO_SUPPRESS_EN selects the suppressed forms.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ascii_line_streamer;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        mode      = 1'b0;
    logic        in_valid  = 1'b0;
    logic        flush     = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] in_data   = 16'h0000;
    logic        in_ready;
    logic        out_valid;
    logic        busy;
    logic [7:0]  out_byte;

    int          total = 0;
    int          bad   = 0;
    logic [7:0]  got[$];

    always #5 clk = ~clk;

    ascii_line_streamer #(
        .DIGITS         (4),
        .WORDS_PER_LINE (2),
        .SEP_CHAR       (8'h3B)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_byte  (out_byte),
        .busy      (busy)
    );

    // Record every accepted output byte, sampled mid-cycle
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) got.push_back(out_byte);
    end

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        got.delete();
    endtask

    task automatic push_word(input logic [15:0] d, input logic m);
        for (int i = 0; i < 50 && !in_ready; i++) begin
            @(posedge clk); #1;
        end
        if (!in_ready) begin
            total++; bad++;
            $display("FAIL push_timeout in_ready=%0b required=1", in_ready);
        end
        in_valid = 1'b1; in_data = d; mode = m;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && busy; i++) begin
            @(posedge clk); #1;
        end
        if (busy) begin
            total++; bad++;
            $display("FAIL idle_timeout busy=%0b required=0", busy);
        end
    endtask

    task automatic test_reset();
        out_ready = 1'b1; in_valid = 1'b1; rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%0b exp=0", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0b exp=0", out_valid); end
        total++; if (out_byte !== 8'h00) begin bad++; $display("FAIL rst_out_byte got=%h exp=00", out_byte); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b exp=0", busy); end
        in_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_in_ready got=%0b exp=1", in_ready); end
        got.delete();
    endtask

    task automatic test_hex();
        logic [7:0] exp[$];
        do_reset();
        out_ready = 1'b1;
        push_word(16'h12AF, 1'b1);
        total++; if (out_valid !== 1'b1 || out_byte !== 8'h31) begin
            bad++; $display("FAIL hex_latency valid=%0b byte=%h exp valid=1 byte=31", out_valid, out_byte);
        end
        wait_idle();
        total++; if (busy !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL hex_idle busy=%0b in_ready=%0b exp 0/1", busy, in_ready);
        end
        exp = '{8'h31, 8'h32, 8'h41, 8'h46, 8'h3B};
        total++; if (got.size() != exp.size()) begin bad++; $display("FAIL hex_len got=%0d exp=%0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            total++;
            if (i >= got.size() || got[i] !== exp[i]) begin
                bad++; $display("FAIL hex_byte%0d got=%h exp=%h", i, (i < got.size()) ? got[i] : 8'h00, exp[i]);
            end
        end
    endtask

    task automatic test_legacy();
        logic [7:0] exp[$];
        do_reset();
        out_ready = 1'b1;
        push_word(16'hCDEF, 1'b0);
        wait_idle();
        push_word(16'hAB90, 1'b0);
        wait_idle();
        exp = '{8'h0D, 8'h0A, 8'h3B, 8'h46, 8'h3B, 8'h0D, 8'h0D, 8'h39, 8'h30, 8'h0D, 8'h0A};
        total++; if (got.size() != exp.size()) begin bad++; $display("FAIL legacy_len got=%0d exp=%0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            total++;
            if (i >= got.size() || got[i] !== exp[i]) begin
                bad++; $display("FAIL legacy_byte%0d got=%h exp=%h", i, (i < got.size()) ? got[i] : 8'h00, exp[i]);
            end
        end
    endtask

    task automatic test_line_break();
        logic [7:0] exp[$];
        do_reset();
        out_ready = 1'b1;
        push_word(16'h0001, 1'b1); wait_idle();
        push_word(16'h0002, 1'b1); wait_idle();
        push_word(16'h0003, 1'b1); wait_idle();
`ifdef ZERO_SUPPRESS_EN
        exp = '{8'h31, 8'h3B, 8'h32, 8'h0D, 8'h0A, 8'h33, 8'h3B};
`else
        exp = '{8'h30, 8'h30, 8'h30, 8'h31, 8'h3B, 8'h30, 8'h30, 8'h30, 8'h32, 8'h0D, 8'h0A,
                8'h30, 8'h30, 8'h30, 8'h33, 8'h3B};
`endif
        total++; if (got.size() != exp.size()) begin bad++; $display("FAIL line_len got=%0d exp=%0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            total++;
            if (i >= got.size() || got[i] !== exp[i]) begin
                bad++; $display("FAIL line_byte%0d got=%h exp=%h", i, (i < got.size()) ? got[i] : 8'h00, exp[i]);
            end
        end
    endtask

    task automatic test_stall();
        logic [7:0] exp[$];
        do_reset();
        out_ready = 1'b1;
        push_word(16'h1234, 1'b1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b1 || out_byte !== 8'h32) begin
            bad++; $display("FAIL stall_start valid=%0b byte=%h exp 1/32", out_valid, out_byte);
        end
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            total++; if (out_valid !== 1'b1 || out_byte !== 8'h32) begin
                bad++; $display("FAIL stall_hold%0d valid=%0b byte=%h exp 1/32", k, out_valid, out_byte);
            end
        end
        out_ready = 1'b1;
        wait_idle();
        exp = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h3B};
        total++; if (got.size() != exp.size()) begin bad++; $display("FAIL stall_len got=%0d exp=%0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            total++;
            if (i >= got.size() || got[i] !== exp[i]) begin
                bad++; $display("FAIL stall_byte%0d got=%h exp=%h", i, (i < got.size()) ? got[i] : 8'h00, exp[i]);
            end
        end
    endtask

    task automatic test_flush();
        logic [7:0] exp[$];
        do_reset();
        out_ready = 1'b1;
        push_word(16'h1234, 1'b1);
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        wait_idle();
        exp = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h0D, 8'h0A};
        total++; if (got.size() != exp.size()) begin bad++; $display("FAIL flush_len got=%0d exp=%0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            total++;
            if (i >= got.size() || got[i] !== exp[i]) begin
                bad++; $display("FAIL flush_byte%0d got=%h exp=%h", i, (i < got.size()) ? got[i] : 8'h00, exp[i]);
            end
        end
        // Flush in IDLE with an empty line produces nothing
        got.delete();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        total++; if (got.size() != 0 || busy !== 1'b0) begin
            bad++; $display("FAIL flush_idle_empty bytes=%0d busy=%0b exp 0/0", got.size(), busy);
        end
        // Flush in IDLE with a partial line closes it
        push_word(16'h0005, 1'b1);
        wait_idle();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        wait_idle();
`ifdef ZERO_SUPPRESS_EN
        exp = '{8'h35, 8'h3B, 8'h0D, 8'h0A};
`else
        exp = '{8'h30, 8'h30, 8'h30, 8'h35, 8'h3B, 8'h0D, 8'h0A};
`endif
        total++; if (got.size() != exp.size()) begin bad++; $display("FAIL flush_idle_len got=%0d exp=%0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            total++;
            if (i >= got.size() || got[i] !== exp[i]) begin
                bad++; $display("FAIL flush_idle_byte%0d got=%h exp=%h", i, (i < got.size()) ? got[i] : 8'h00, exp[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp[$];
        do_reset();
        out_ready = 1'b1;
        push_word(16'h0007, 1'b1);
        wait_idle();
        push_word(16'h1234, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            bad++; $display("FAIL midrst valid=%0b busy=%0b in_ready=%0b exp 0/0/0", out_valid, busy, in_ready);
        end
        rst_n = 1'b1;
        got.delete();
        push_word(16'h0009, 1'b1);
        wait_idle();
`ifdef ZERO_SUPPRESS_EN
        exp = '{8'h39, 8'h3B};
`else
        exp = '{8'h30, 8'h30, 8'h30, 8'h39, 8'h3B};
`endif
        total++; if (got.size() != exp.size()) begin bad++; $display("FAIL midrst_len got=%0d exp=%0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            total++;
            if (i >= got.size() || got[i] !== exp[i]) begin
                bad++; $display("FAIL midrst_byte%0d got=%h exp=%h", i, (i < got.size()) ? got[i] : 8'h00, exp[i]);
            end
        end
    endtask

    task automatic test_zero();
        logic [7:0] exp[$];
        do_reset();
        out_ready = 1'b1;
        push_word(16'h0000, 1'b1); wait_idle();
        push_word(16'h00A5, 1'b1); wait_idle();
`ifdef ZERO_SUPPRESS_EN
        exp = '{8'h30, 8'h3B, 8'h41, 8'h35, 8'h0D, 8'h0A};
`else
        exp = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h3B, 8'h30, 8'h30, 8'h41, 8'h35, 8'h0D, 8'h0A};
`endif
        total++; if (got.size() != exp.size()) begin bad++; $display("FAIL zero_len got=%0d exp=%0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            total++;
            if (i >= got.size() || got[i] !== exp[i]) begin
                bad++; $display("FAIL zero_byte%0d got=%h exp=%h", i, (i < got.size()) ? got[i] : 8'h00, exp[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_hex();
        test_legacy();
        test_line_break();
        test_stall();
        test_flush();
        test_reset_mid();
        test_zero();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
